// File: rtl/traffic_light_controller.sv
// traffic_light_controller
// Two-road (NS/EW) signal sequencer. Runs a timed green/yellow/all-red cycle
// with a pedestrian early-yield on NS green, and hands the lamps over to an
// external flasher while flash mode is requested. All lamps except the two
// flash lamps come straight from registers; in flash mode flash_in is gated
// onto NS yellow and EW red.

module traffic_light_controller #(
   parameter int GREEN_CYCLES  = 20,
   parameter int MIN_GREEN     = 8,
   parameter int YELLOW_CYCLES = 6,
   parameter int ALLRED_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic flash_req,
   input  logic ped_request,
   input  logic flash_in,
   output logic flasher_enable,
   output logic flasher_idle,
   output logic ns_red,
   output logic ns_yellow,
   output logic ns_green,
   output logic ew_red,
   output logic ew_yellow,
   output logic ew_green,
   output logic ped_pending
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // ------------------------------------------------------------------
   if (GREEN_CYCLES < 2) begin : g_chk_green
      $error("GREEN_CYCLES must be at least 2");
   end
   if ((MIN_GREEN < 1) || (MIN_GREEN > GREEN_CYCLES)) begin : g_chk_min_green
      $error("MIN_GREEN must lie in 1..GREEN_CYCLES");
   end
   if (YELLOW_CYCLES < 1) begin : g_chk_yellow
      $error("YELLOW_CYCLES must be at least 1");
   end
   if (ALLRED_CYCLES < 1) begin : g_chk_allred
      $error("ALLRED_CYCLES must be at least 1");
   end
   if (((GREEN_CYCLES >> CNT_W) != 0) || ((YELLOW_CYCLES >> CNT_W) != 0) ||
       ((ALLRED_CYCLES >> CNT_W) != 0)) begin : g_chk_width
      $error("phase durations must fit in CNT_W bits");
   end

   // ------------------------------------------------------------------
   // Types and constants
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_AR1   = 3'd0,
      ST_NSG   = 3'd1,
      ST_NSY   = 3'd2,
      ST_AR2   = 3'd3,
      ST_EWG   = 3'd4,
      ST_EWY   = 3'd5,
      ST_FLASH = 3'd6
   } state_t;

   // Timer reload values: a phase of N clocks counts N-1 down to 0.
   localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMER_ZERO  = '0;

   // elapsed = GREEN_LOAD - timer, and elapsed >= MIN_GREEN-1 is the same
   // as timer <= GREEN_CYCLES-MIN_GREEN; comparing the timer directly
   // avoids a subtractor.
   localparam logic [CNT_W-1:0] YIELD_LIMIT = CNT_W'(GREEN_CYCLES - MIN_GREEN);

   // Lamp vector bit order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
   localparam int        LAMP_N     = 6;
   localparam logic [5:0] LAMPS_ALLRED = 6'b100_100;
   localparam logic [5:0] LAMPS_NSG    = 6'b001_100;
   localparam logic [5:0] LAMPS_NSY    = 6'b010_100;
   localparam logic [5:0] LAMPS_EWG    = 6'b100_001;
   localparam logic [5:0] LAMPS_EWY    = 6'b100_010;
   // Lamps that follow flash_in while flashing: NS yellow and EW red.
   localparam logic [5:0] FLASH_MASK   = 6'b010_100;

   // Lamp pattern for each steady state; FLASH lamps come from flash_in.
   function automatic logic [5:0] lamp_decode(input state_t s);
      logic [5:0] l;
      l = LAMPS_ALLRED;
      case (s)
         ST_AR1, ST_AR2: l = LAMPS_ALLRED;
         ST_NSG:         l = LAMPS_NSG;
         ST_NSY:         l = LAMPS_NSY;
         ST_EWG:         l = LAMPS_EWG;
         ST_EWY:         l = LAMPS_EWY;
         ST_FLASH:       l = '0;
         default:        l = LAMPS_ALLRED;
      endcase
      return l;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t             state_reg,   state_next;
   logic [CNT_W-1:0]   timer_reg,   timer_next;
   logic               pending_reg, pending_next;
   logic [LAMP_N-1:0]  lamp_reg,    lamp_next;
   logic               flash_mode_reg;
   logic               flash_mode_next;

   logic               phase_done;
   logic               ped_yield;
   logic [LAMP_N-1:0]  lamp_out;
   logic [CNT_W-1:0]   timer_limit;

   assign phase_done = (timer_reg == TIMER_ZERO);
   assign ped_yield  = pending_reg && (timer_reg <= YIELD_LIMIT);

   // Next-state, timer reload and pedestrian latch logic.
   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg;
      pending_next = pending_reg;

      case (state_reg)
         ST_AR1: begin
            if (phase_done) begin
               if (flash_req) begin
                  state_next = ST_FLASH;
                  timer_next = TIMER_ZERO;
               end else begin
                  state_next = ST_NSG;
                  timer_next = GREEN_LOAD;
               end
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end
         ST_NSG: begin
            // A latched pedestrian request may end NS green early, but
            // never before MIN_GREEN clocks have been shown.
            if (phase_done || ped_yield) begin
               state_next = ST_NSY;
               timer_next = YELLOW_LOAD;
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end
         ST_NSY: begin
            if (phase_done) begin
               state_next = ST_AR2;
               timer_next = ALLRED_LOAD;
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end
         ST_AR2: begin
            if (phase_done) begin
               if (flash_req) begin
                  state_next = ST_FLASH;
                  timer_next = TIMER_ZERO;
               end else begin
                  state_next = ST_EWG;
                  timer_next = GREEN_LOAD;
               end
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end
         ST_EWG: begin
            if (phase_done) begin
               state_next = ST_EWY;
               timer_next = YELLOW_LOAD;
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end
         ST_EWY: begin
            if (phase_done) begin
               state_next = ST_AR1;
               timer_next = ALLRED_LOAD;
            end else begin
               timer_next = timer_reg - TIMER_ONE;
            end
         end
         ST_FLASH: begin
            // Leaving flash always passes through a full all-red clearance.
            if (!flash_req) begin
               state_next = ST_AR1;
               timer_next = ALLRED_LOAD;
            end else begin
               timer_next = TIMER_ZERO;
            end
         end
         default: begin
            state_next = ST_AR1;
            timer_next = ALLRED_LOAD;
         end
      endcase

      // The EW green phase serves the crossing, so the request is retired
      // on entry; a request on that very clock is kept for the next cycle.
      if ((state_reg == ST_AR2) && (state_next == ST_EWG)) begin
         pending_next = 1'b0;
      end
      if (ped_request) begin
         pending_next = 1'b1;
      end
   end

   assign lamp_next       = lamp_decode(state_next);
   assign flash_mode_next = (state_next == ST_FLASH);

   // Single FSM register bank: state, timer, latch and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_AR1;
         timer_reg      <= ALLRED_LOAD;
         pending_reg    <= 1'b0;
         lamp_reg       <= LAMPS_ALLRED;
         flash_mode_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         pending_reg    <= pending_next;
         lamp_reg       <= lamp_next;
         flash_mode_reg <= flash_mode_next;
      end
   end

   // ------------------------------------------------------------------
   // Lamp drive: registered pattern, or flash_in on the flash lamps
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < LAMP_N; gi++) begin : g_lamp
      assign lamp_out[gi] = flash_mode_reg ? (FLASH_MASK[gi] & flash_in)
                                           : lamp_reg[gi];
   end

   assign ns_red         = lamp_out[5];
   assign ns_yellow      = lamp_out[4];
   assign ns_green       = lamp_out[3];
   assign ew_red         = lamp_out[2];
   assign ew_yellow      = lamp_out[1];
   assign ew_green       = lamp_out[0];
   assign ped_pending    = pending_reg;
   assign flasher_enable = flash_mode_reg;
   assign flasher_idle   = 1'b0;

   // ------------------------------------------------------------------
   // Simulation checks: the timer never exceeds the current phase reload
   // value (an underflow would wrap to all ones), and the two roads are
   // never released together.
   // ------------------------------------------------------------------
   // Largest legal timer value for the current state.
   always_comb begin
      timer_limit = TIMER_ZERO;
      case (state_reg)
         ST_AR1, ST_AR2: timer_limit = ALLRED_LOAD;
         ST_NSG, ST_EWG: timer_limit = GREEN_LOAD;
         ST_NSY, ST_EWY: timer_limit = YELLOW_LOAD;
         default:        timer_limit = TIMER_ZERO;
      endcase
   end

   a_timer_no_underflow : assert property (
      @(posedge clock) disable iff (reset) (timer_reg <= timer_limit));

   a_roads_exclusive : assert property (
      @(posedge clock) disable iff (reset)
      !((lamp_reg[4] || lamp_reg[3]) && (lamp_reg[1] || lamp_reg[0])));

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller
// Directed scenarios plus randomized stimulus, compared every clock against
// a phase-table reference model (phase index + clocks spent in phase).

module tb_traffic_light_controller;

   localparam int G  = 8;
   localparam int MG = 4;
   localparam int Y  = 3;
   localparam int AR = 2;

   // Phase numbering of the model: 0 AR1, 1 NSG, 2 NSY, 3 AR2, 4 EWG, 5 EWY, 6 FLASH
   localparam int P_FLASH = 6;
   int dur [6] = '{AR, G, Y, AR, G, Y};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flash_req = 1'b0;
   logic ped_request = 1'b0;
   logic flash_in = 1'b0;
   logic flasher_enable, flasher_idle;
   logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_pending;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b0;

   int m_phase = 0;
   int m_cnt = 0;
   bit m_pend = 1'b0;

   always #5 clk = ~clk;

   traffic_light_controller #(
      .GREEN_CYCLES(G), .MIN_GREEN(MG), .YELLOW_CYCLES(Y),
      .ALLRED_CYCLES(AR), .CNT_W(16)
   ) dut (
      .clock(clk), .reset(rst), .flash_req(flash_req), .ped_request(ped_request),
      .flash_in(flash_in), .flasher_enable(flasher_enable), .flasher_idle(flasher_idle),
      .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
      .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
      .ped_pending(ped_pending)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_lamps(input int p, input logic fi);
      case (p)
         0, 3:    return 8'b00_100100;
         1:       return 8'b00_001100;
         2:       return 8'b00_010100;
         4:       return 8'b00_100001;
         5:       return 8'b00_100010;
         default: return {3'b000, fi, 1'b0, fi, 2'b00};
      endcase
   endfunction

   function automatic logic [7:0] dut_lamps();
      return {2'b00, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
   endfunction

   // Reference model: advance phase/clock count from the phase-duration table.
   always @(posedge clk) begin
      int p, c;
      bit pn, done;
      if (rst) begin
         m_phase <= 0;
         m_cnt   <= 0;
         m_pend  <= 1'b0;
      end else begin
         p  = m_phase;
         c  = m_cnt;
         pn = m_pend;
         if (m_phase == P_FLASH) begin
            if (!flash_req) begin
               p = 0;
               c = 0;
            end
         end else begin
            done = (m_cnt == dur[m_phase] - 1) ||
                   (m_phase == 1 && m_pend && m_cnt >= MG - 1);
            if (done) begin
               p = (m_phase + 1) % 6;
               c = 0;
               if ((m_phase == 0 || m_phase == 3) && flash_req) p = P_FLASH;
            end else begin
               c = m_cnt + 1;
            end
         end
         if (m_phase == 3 && p == 4) pn = 1'b0;
         if (ped_request) pn = 1'b1;
         m_phase <= p;
         m_cnt   <= c;
         m_pend  <= pn;
      end
   end

   // Compare process: every cycle once the DUT has seen a reset edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("lamps", dut_lamps(), exp_lamps(m_phase, flash_in));
         check("ped_pending", {7'b0, ped_pending}, {7'b0, m_pend});
         check("flasher_enable", {7'b0, flasher_enable}, {7'b0, m_phase == P_FLASH});
         check("flasher_idle", {7'b0, flasher_idle}, 8'd0);
         check("roads_exclusive", {7'b0, (ns_green | ns_yellow) & (ew_green | ew_yellow)}, 8'd0);
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Returns at the negedge of the first cycle where sig_sel is lit.
   // sig_sel: 0 ns_green, 1 ew_green, 2 ew_yellow, 3 flasher_enable
   task automatic wait_for(input int sig_sel, input string name, output int waited);
      bit ok;
      logic v;
      ok = 1'b0;
      waited = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         waited++;
         case (sig_sel)
            0:       v = ns_green;
            1:       v = ew_green;
            2:       v = ew_yellow;
            default: v = flasher_enable;
         endcase
         if (v === 1'b1) ok = 1'b1;
      end
      if (!ok) check({"timeout_", name}, 8'd0, 8'd1);
   endtask

   // Measures an NS green run; optional one-clock ped pulse in cycle pulse_at.
   task automatic measure_green(input int pulse_at, output int len);
      int w;
      bit ended;
      wait_for(0, "ns_green", w);
      len = 1;
      ended = 1'b0;
      for (int k = 0; k < 100 && !ended; k++) begin
         #1 ped_request = (len == pulse_at);
         @(negedge clk);
         if (ns_green !== 1'b1) ended = 1'b1;
         else len++;
      end
      #1 ped_request = 1'b0;
      if (!ended) check("timeout_green_end", 8'd0, 8'd1);
   endtask

   initial begin
      int len, w, n;
      // 1: reset 2 clocks, then free-run
      @(posedge clk);
      check_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_allred", dut_lamps(), 8'b00_100100);
      measure_green(0, len);
      check("nsg_len_free", len[7:0], 8'd8);
      wait_for(1, "ew_green", w);
      check("ewg_after_nsg", {ns_red, ew_green, 6'b0}, {2'b11, 6'b0});
      measure_green(0, len);
      // From the second cycle on the period is 26 clocks.
      cycles(60);

      // 2: pulse at NSG clock 1 -> 4-clock green
      measure_green(1, len);
      check("nsg_len_ped1", len[7:0], 8'd4);
      wait_for(1, "ew_green", w);
      check("pending_cleared_ewg", {7'b0, ped_pending}, 8'd0);

      // 3: pulse at NSG clock 6 -> 7-clock green
      measure_green(6, len);
      check("nsg_len_ped6", len[7:0], 8'd7);
      wait_for(1, "ew_green", w);
      #1 ped_request = 1'b1;
      @(negedge clk);
      #1 ped_request = 1'b0;
      @(negedge clk);
      check("pending_held_ewg", {7'b0, ped_pending}, 8'd1);
      measure_green(0, len);
      check("nsg_len_pending", len[7:0], 8'd4);

      // 4: flash request at NSG clock 3; green/yellow/all-red finish first
      wait_for(0, "ns_green", w);
      cycles(2);
      #1 flash_req = 1'b1;
      wait_for(3, "flasher_enable", w);
      check("flash_entry_delay", w[7:0], 8'd11);
      for (int i = 0; i < 30; i++) begin
         if (i % 5 == 0) #1 flash_in = ~flash_in;
         @(negedge clk);
      end
      #1 flash_in = 1'b1;
      @(negedge clk);
      check("flash_lamps_on", dut_lamps(), 8'b00_010100);

      // 5: leave flash -> AR1 for 2 clocks, then NSG
      #1 flash_req = 1'b0;
      @(negedge clk);
      check("flash_exit_enable", {7'b0, flasher_enable}, 8'd0);
      n = 1;
      for (int i = 0; i < 20 && ns_red === 1'b1 && ew_red === 1'b1; i++) begin
         @(negedge clk);
         if (ns_red === 1'b1 && ew_red === 1'b1) n++;
      end
      check("flash_exit_allred", n[7:0], 8'd2);
      check("flash_exit_nsg", {7'b0, ns_green}, 8'd1);

      // 6: reset mid-EWY (with ped request) and mid-FLASH
      wait_for(2, "ew_yellow", w);
      #1 rst = 1'b1;
      ped_request = 1'b1;
      @(negedge clk);
      check("rst_ewy_lamps", dut_lamps(), 8'b00_100100);
      check("rst_ewy_pending", {7'b0, ped_pending}, 8'd0);
      #1 rst = 1'b0;
      ped_request = 1'b0;
      flash_req = 1'b1;
      wait_for(3, "flasher_enable", w);
      cycles(3);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_flash_lamps", dut_lamps(), 8'b00_100100);
      check("rst_flash_enable", {7'b0, flasher_enable}, 8'd0);
      #1 rst = 1'b0;
      cycles(5);
      #1 flash_req = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         #1;
         ped_request = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) flash_req = ~flash_req;
         if ($urandom_range(0, 3) == 0) flash_in = ~flash_in;
         rst = ($urandom_range(0, 599) == 0);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
